// File: rtl/pll_md_ctrl_if.sv
// rtl/pll_md_ctrl_if.sv - command/response and MD bus signals of the PLL MD master
interface pll_md_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       pll_reset;
    logic       pll_lock;
    logic       mdclk;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, pll_lock, mdrdo,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, pll_reset,
               mdclk, mdopc, mdainc, mdwdi
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, pll_lock, mdrdo,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, pll_reset,
               mdclk, mdopc, mdainc, mdwdi
    );
endinterface

// File: rtl/pll_md_ctrl.sv
// rtl/pll_md_ctrl.sv - PLL dynamic-reconfiguration port master with apply/relock sequencing
module pll_md_ctrl #(
    parameter int MDCLK_DIV    = 4,
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          reset,
    pll_md_ctrl_if.master bus
);
    localparam int               DIV_W     = (MDCLK_DIV > 1) ? $clog2(MDCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MDCLK_DIV - 1);
    localparam logic [31:0]      RST_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]      LOCK_LAST = 32'(LOCK_TIMEOUT);

    localparam logic [1:0] OPC_NOP   = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_READ  = 2'b10;
    localparam logic [1:0] OPC_ADDR  = 2'b11;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_APPLY = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WAIT_FALL, ADDR, DATA, NOP, RD_CAP, RST_PULSE, WAIT_LOCK
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mdclk_q, mdclk_d;
    logic [1:0]       mdopc_q, mdopc_d;
    logic             mdainc_q, mdainc_d;
    logic [7:0]       mdwdi_q, mdwdi_d;
    logic             ready_q, ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             pll_reset_q, pll_reset_d;
    logic             lock_meta_q, lock_meta_d;
    logic             lock_sync_q, lock_sync_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       shadow_q, shadow_d;
    logic             shadow_valid_q, shadow_valid_d;
    logic [31:0]      cnt_q, cnt_d;

    logic       fall_tick;
    logic       rise_tick;
    logic [1:0] data_opc;
    logic [7:0] data_wdi;
    logic       need_addr;

    assign fall_tick = (div_q == DIV_LAST) && mdclk_q;
    assign rise_tick = (div_q == DIV_LAST) && !mdclk_q;
    assign data_opc  = (op_q == CMD_WRITE) ? OPC_WRITE : OPC_READ;
    assign data_wdi  = (op_q == CMD_WRITE) ? wdata_q : 8'h00;
    assign need_addr = !shadow_valid_q || (addr_q != shadow_q);

    always_comb begin
        state_d        = state_q;
        div_d          = div_q + DIV_W'(1);
        mdclk_d        = mdclk_q;
        mdopc_d        = mdopc_q;
        mdainc_d       = mdainc_q;
        mdwdi_d        = mdwdi_q;
        ready_d        = ready_q;
        rsp_valid_d    = 1'b0;
        rsp_err_d      = rsp_err_q;
        rsp_rdata_d    = rsp_rdata_q;
        pll_reset_d    = pll_reset_q;
        lock_meta_d    = bus.pll_lock;
        lock_sync_d    = lock_meta_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        cnt_d          = cnt_q;

        if (div_q == DIV_LAST) begin
            div_d   = '0;
            mdclk_d = ~mdclk_q;
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    op_d    = bus.cmd_op;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    case (bus.cmd_op)
                        CMD_WRITE, CMD_READ: state_d = WAIT_FALL;
                        CMD_APPLY: begin
                            state_d        = RST_PULSE;
                            pll_reset_d    = 1'b1;
                            cnt_d          = '0;
                            shadow_valid_d = 1'b0;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_FALL: begin
                if (fall_tick) begin
                    if (need_addr) begin
                        mdopc_d  = OPC_ADDR;
                        mdwdi_d  = addr_q;
                        mdainc_d = 1'b0;
                        state_d  = ADDR;
                    end else begin
                        mdopc_d  = data_opc;
                        mdwdi_d  = data_wdi;
                        mdainc_d = 1'b1;
                        state_d  = DATA;
                    end
                end
            end
            ADDR: begin
                if (fall_tick) begin
                    mdopc_d  = data_opc;
                    mdwdi_d  = data_wdi;
                    mdainc_d = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (fall_tick) begin
                    mdopc_d        = OPC_NOP;
                    mdwdi_d        = 8'h00;
                    mdainc_d       = 1'b0;
                    shadow_d       = addr_q + 8'd1;
                    shadow_valid_d = 1'b1;
                    if (op_q == CMD_WRITE) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        ready_d     = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = NOP;
                    end
                end
            end
            // Read data is valid at the rise that samples the trailing NOP.
            NOP: begin
                if (rise_tick) begin
                    rsp_rdata_d = bus.mdrdo;
                    state_d     = RD_CAP;
                end
            end
            RD_CAP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                ready_d     = 1'b1;
                state_d     = IDLE;
            end
            RST_PULSE: begin
                if (cnt_q == RST_LAST) begin
                    pll_reset_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_LOCK: begin
                if (cnt_q == LOCK_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end else if (lock_sync_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            div_q          <= '0;
            mdclk_q        <= 1'b0;
            mdopc_q        <= OPC_NOP;
            mdainc_q       <= 1'b0;
            mdwdi_q        <= 8'h00;
            ready_q        <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= 8'h00;
            pll_reset_q    <= 1'b0;
            lock_meta_q    <= 1'b0;
            lock_sync_q    <= 1'b0;
            op_q           <= CMD_WRITE;
            addr_q         <= 8'h00;
            wdata_q        <= 8'h00;
            shadow_q       <= 8'h00;
            shadow_valid_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            mdclk_q        <= mdclk_d;
            mdopc_q        <= mdopc_d;
            mdainc_q       <= mdainc_d;
            mdwdi_q        <= mdwdi_d;
            ready_q        <= ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_rdata_q    <= rsp_rdata_d;
            pll_reset_q    <= pll_reset_d;
            lock_meta_q    <= lock_meta_d;
            lock_sync_q    <= lock_sync_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            cnt_q          <= cnt_d;
        end
    end

    // ready_q sits at 1 through reset so the port is ready on the first cycle after release.
    assign bus.cmd_ready = ready_q & ~reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.pll_reset = pll_reset_q;
    assign bus.mdclk     = mdclk_q;
    assign bus.mdopc     = mdopc_q;
    assign bus.mdainc    = mdainc_q;
    assign bus.mdwdi     = mdwdi_q;
endmodule

// File: tb/tb_pll_md_ctrl.sv
// tb/tb_pll_md_ctrl.sv - table-driven scoreboard bench for pll_md_ctrl
`timescale 1ns/1ps
module tb_pll_md_ctrl;
    localparam int DIV     = 2;
    localparam int RST_CYC = 16;
    localparam int TMO     = 1000;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_AP  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [1:0] MD_NOP = 2'b00;
    localparam logic [1:0] MD_WR  = 2'b01;
    localparam logic [1:0] MD_RD  = 2'b10;
    localparam logic [1:0] MD_AD  = 2'b11;

    typedef struct packed {
        logic [1:0] opc;
        logic       ainc;
        logic [7:0] wdi;
    } md_t;

    typedef struct packed {
        logic       err;
        logic       chk_rd;
        logic [7:0] rdata;
    } rsp_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd_model;
        bit         addr_phase;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pll_md_ctrl_if bus();

    pll_md_ctrl #(
        .MDCLK_DIV   (DIV),
        .RESET_CYCLES(RST_CYC),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    md_t        md_q[$];
    rsp_t       rsp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rsp_cnt = 0;
    int         rsp_cyc = 0;
    int         pr_cnt = 0;
    int         pr_first = 0;
    int         pr_fall = 0;
    logic       pr_prev = 1'b0;
    logic [7:0] rd_model = 8'h00;
    md_t        md_prev;
    int         md_hold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // PLL model: the READ op sampled at an mdclk rise returns its data before the next rise.
    always @(posedge bus.mdclk) begin
        if (bus.mdopc == MD_RD) bus.mdrdo = rd_model;
    end

    always @(negedge clk) begin : rsp_mon
        rsp_t e;
        if (!reset && bus.rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid with err=%0b expected none", bus.rsp_err);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                if (e.chk_rd) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            end
        end
    end

    always @(negedge clk) begin : md_mon
        md_t cur;
        md_t e;
        cur = {bus.mdopc, bus.mdainc, bus.mdwdi};
        if (reset) begin
            md_prev = cur;
            md_hold = 0;
        end else if (cur !== md_prev) begin
            check("md_on_fall", 32'(bus.mdclk), 32'(0));
            if (md_prev.opc != MD_NOP) check("md_hold", md_hold, 2 * DIV);
            if (md_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL md_unexpected: got %0h expected no bus change", cur);
            end else begin
                e = md_q.pop_front();
                check("md_op", 32'(cur), 32'(e));
            end
            md_prev = cur;
            md_hold = 1;
        end else begin
            md_hold++;
        end
    end

    always @(negedge clk) begin : pr_mon
        if (reset) begin
            pr_prev = 1'b0;
        end else begin
            if (bus.pll_reset) begin
                if (!pr_prev) pr_first = cyc;
                pr_cnt++;
            end else if (pr_prev) begin
                pr_fall = cyc;
            end
            pr_prev = bus.pll_reset;
        end
    end

    task automatic check_reset_vals(input string name);
        check(name, {8'h00, bus.cmd_ready, bus.mdclk, bus.mdopc, bus.mdainc, bus.mdwdi,
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.pll_reset}, 32'h0);
    endtask

    task automatic wait_fall();
        logic prev;
        prev = bus.mdclk;
        for (int i = 0; i < 8 * DIV; i++) begin
            @(negedge clk);
            if (prev && !bus.mdclk) return;
            prev = bus.mdclk;
        end
        fail_bound("mdclk_fall");
    endtask

    // Presents a command, then keeps cmd_valid up for one cycle with garbage that must be ignored.
    task automatic send(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                        output int acc);
        int n;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) fail_bound("cmd_accept");
        @(negedge clk);
        acc = cyc;
        check("cmd_ready_drop", 32'(bus.cmd_ready), 32'(0));
        bus.cmd_op    = OP_ILL;
        bus.cmd_addr  = ~addr;
        bus.cmd_wdata = ~wdata;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int limit);
        int n;
        n = 0;
        while (rsp_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (rsp_cnt < target) fail_bound("rsp_timeout");
    endtask

    task automatic run_vec(input vec_t v, output int lat);
        int acc;
        int base;
        if (v.op == OP_WR || v.op == OP_RD) begin
            if (v.addr_phase) md_q.push_back({MD_AD, 1'b0, v.addr});
            if (v.op == OP_WR) md_q.push_back({MD_WR, 1'b1, v.wdata});
            else               md_q.push_back({MD_RD, 1'b1, 8'h00});
            md_q.push_back({MD_NOP, 1'b0, 8'h00});
            rd_model = v.rd_model;
            wait_fall();
        end
        rsp_q.push_back({v.exp_err, (v.op == OP_RD), v.rd_model});
        base = rsp_cnt;
        send(v.op, v.addr, v.wdata, acc);
        wait_rsp(base + 1, 200);
        lat = rsp_cyc - acc;
    endtask

    initial begin : main
        vec_t tv[8];
        int   lat[8];
        vec_t v;
        int   l;
        int   acc;
        int   base;
        int   n;
        int   d;

        tv[0] = '{OP_WR,  8'h12, 8'h5A, 8'h00, 1'b1, 1'b0};
        tv[1] = '{OP_WR,  8'h13, 8'h77, 8'h00, 1'b0, 1'b0};
        tv[2] = '{OP_RD,  8'h20, 8'h00, 8'hC3, 1'b1, 1'b0};
        tv[3] = '{OP_RD,  8'h21, 8'h00, 8'h3C, 1'b0, 1'b0};
        tv[4] = '{OP_WR,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tv[5] = '{OP_WR,  8'h00, 8'h02, 8'h00, 1'b0, 1'b0};
        tv[6] = '{OP_ILL, 8'h44, 8'h00, 8'h00, 1'b0, 1'b1};
        tv[7] = '{OP_WR,  8'h05, 8'hAA, 8'h00, 1'b1, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_WR;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.pll_lock  = 1'b0;
        bus.mdrdo     = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(bus.cmd_ready), 32'(1));

        for (int i = 0; i < 8; i++) begin
            run_vec(tv[i], l);
            lat[i] = l;
        end
        check("lat_write_skip_addr", lat[1], lat[0] - 2 * DIV);
        check("lat_read_skip_addr", lat[3], lat[2] - 2 * DIV);
        check("lat_wrap_skip_addr", lat[5], lat[4] - 2 * DIV);
        check("lat_illegal", lat[6], 0);
        check("no_reset_activity", pr_cnt, 0);

        // Apply with lock arriving 100 cycles after pll_reset release.
        pr_cnt = 0;
        rsp_q.push_back({1'b0, 1'b0, 8'h00});
        base = rsp_cnt;
        send(OP_AP, 8'h00, 8'h00, acc);
        n = 0;
        while ((pr_cnt == 0 || bus.pll_reset) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.pll_reset || pr_cnt == 0) fail_bound("pll_reset_fall");
        repeat (100) @(negedge clk);
        bus.pll_lock = 1'b1;
        wait_rsp(base + 1, 200);
        check("apply_reset_len", pr_cnt, RST_CYC);
        check("apply_reset_start", pr_first, acc);
        d = rsp_cyc - pr_fall;
        check("apply_lock_time", 32'(d >= 100 && d <= 106), 32'(1));

        v = '{OP_WR, 8'h06, 8'h11, 8'h00, 1'b1, 1'b0};
        run_vec(v, l);

        // Apply with lock held low: response carries the timeout error.
        bus.pll_lock = 1'b0;
        repeat (4) @(negedge clk);
        pr_cnt = 0;
        rsp_q.push_back({1'b1, 1'b0, 8'h00});
        base = rsp_cnt;
        send(OP_AP, 8'h00, 8'h00, acc);
        wait_rsp(base + 1, RST_CYC + TMO + 100);
        check("timeout_reset_len", pr_cnt, RST_CYC);
        d = rsp_cyc - pr_fall;
        check("timeout_time", 32'(d >= TMO && d <= TMO + 3), 32'(1));

        // Reset while the READ op is on the bus: no response, clean restart.
        md_q.push_back({MD_AD, 1'b0, 8'h31});
        md_q.push_back({MD_RD, 1'b1, 8'h00});
        rd_model = 8'h99;
        wait_fall();
        base = rsp_cnt;
        send(OP_RD, 8'h31, 8'h00, acc);
        n = 0;
        while (bus.mdopc != MD_RD && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.mdopc != MD_RD) fail_bound("read_op");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midread_reset_values");
        check("midread_md_drained", md_q.size(), 0);
        md_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midread_no_rsp", rsp_cnt, base);

        v = '{OP_WR, 8'h31, 8'hA5, 8'h00, 1'b1, 1'b0};
        run_vec(v, l);
        repeat (10) @(negedge clk);
        check("rsp_queue_empty", rsp_q.size(), 0);
        check("md_queue_empty", md_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule
